// File: rtl/speaker_pkg.sv
// Shared definitions for the speaker AXI4-Lite peripheral: register map,
// control bit positions, AXI response codes and the register word type.
// Optional feature macro: SPEAKER_WSTRB_EN (byte-strobe writes).
package speaker_pkg;

    typedef logic [31:0] reg_t;

    // Register indices (byte address bits [3:2])
    localparam logic [1:0] CTRL     = 2'd0;
    localparam logic [1:0] PERIOD   = 2'd1;
    localparam logic [1:0] NOTE_LEN = 2'd2;
    localparam logic [1:0] SCRATCH  = 2'd3;

    localparam int CTRL_EN_BIT = 0;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Merge new write data into an old word, byte by byte, under a strobe mask
    function automatic reg_t apply_wstrb(input reg_t old_word, input reg_t new_word,
                                         input logic [3:0] strb);
        reg_t merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/speaker_tone_gen.sv
// Square-wave tone generator. Runs a half-period counter and a toggle budget;
// a tone starts on a fresh enable with a non-zero period and stops when the
// budget is used up, enable drops or the period becomes zero. After any start
// the enable must go low before another tone can begin.
module speaker_tone_gen
    import speaker_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic enable_i,
    input  reg_t period_i,
    input  reg_t note_len_i,
    output logic speaker_o,
    output logic busy_o
);

    typedef enum logic {
        TONE_IDLE = 1'b0,
        TONE_PLAY = 1'b1
    } tone_state_t;

    tone_state_t state_q;
    reg_t        cnt_q;
    reg_t        left_q;
    logic        endless_q;   // note length was zero at start: never runs out
    logic        hold_q;      // a tone already started on this enable level
    logic        spk_q;

    // Tone state machine, counters and registered speaker output
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= TONE_IDLE;
            cnt_q     <= '0;
            left_q    <= '0;
            endless_q <= 1'b0;
            hold_q    <= 1'b0;
            spk_q     <= 1'b0;
        end else begin
            if (!enable_i) begin
                hold_q <= 1'b0;
            end
            case (state_q)
                TONE_IDLE: begin
                    spk_q <= 1'b0;
                    if (enable_i && (period_i != '0) && !hold_q) begin
                        state_q   <= TONE_PLAY;
                        hold_q    <= 1'b1;
                        cnt_q     <= period_i - 32'd1;
                        left_q    <= note_len_i;
                        endless_q <= (note_len_i == '0);
                    end
                end
                TONE_PLAY: begin
                    if (!enable_i || (period_i == '0) || (!endless_q && (left_q == '0))) begin
                        state_q <= TONE_IDLE;
                        spk_q   <= 1'b0;
                    end else if (cnt_q == '0) begin
                        spk_q <= ~spk_q;
                        // Reload from the live register so period edits apply here
                        cnt_q <= period_i - 32'd1;
                        if (!endless_q) begin
                            left_q <= left_q - 32'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_q <= TONE_IDLE;
                    spk_q   <= 1'b0;
                end
            endcase
        end
    end

    assign speaker_o = spk_q;
    assign busy_o    = (state_q == TONE_PLAY);

endmodule

// File: rtl/speaker_axi_slave.sv
// AXI4-Lite slave for the speaker peripheral: four 32-bit RW registers
// (CTRL, PERIOD, NOTE_LEN, SCRATCH), single-beat write/read handshakes,
// and the tone generator driven from CTRL/PERIOD/NOTE_LEN.
// Optional feature macro: SPEAKER_WSTRB_EN - when defined, writes honour
// s00_axi_wstrb byte lanes; otherwise the full word is always written.
module speaker_axi_slave
    import speaker_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            speaker_out,
    output logic                            tone_busy
);

    logic clk;
    logic srst;
    assign clk  = s00_axi_aclk;
    assign srst = s00_axi_areset;

    reg_t regs_q [4];
    reg_t wr_word [4];

    logic awready_q;
    logic wready_q;
    logic bvalid_q;
    logic arready_q;
    logic rvalid_q;
    reg_t rdata_q;

    logic [1:0] wr_idx;
    logic [1:0] rd_idx;
    logic       wr_fire;
    logic       rd_fire;

    assign wr_idx  = s00_axi_awaddr[3:2];
    assign rd_idx  = s00_axi_araddr[3:2];
    assign wr_fire = awready_q && s00_axi_awvalid && wready_q && s00_axi_wvalid;
    assign rd_fire = arready_q && s00_axi_arvalid;

    // Write channel: accept address and data together, then hold B until taken
    always_ff @(posedge clk) begin
        if (srst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            if (s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q) begin
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end else begin
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register file: one update process per register, written on the handshake cycle
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reg
`ifdef SPEAKER_WSTRB_EN
            assign wr_word[gi] = apply_wstrb(regs_q[gi], s00_axi_wdata, s00_axi_wstrb);
`else
            assign wr_word[gi] = s00_axi_wdata;
`endif
            // Update register gi when the accepted write targets it
            always_ff @(posedge clk) begin
                if (srst) begin
                    regs_q[gi] <= '0;
                end else if (wr_fire && (wr_idx == 2'(gi))) begin
                    regs_q[gi] <= wr_word[gi];
                end
            end
        end
    endgenerate

    // Read channel: accept address, capture data (pre-write value), hold R until taken
    always_ff @(posedge clk) begin
        if (srst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (s00_axi_arvalid && !arready_q && !rvalid_q) begin
                arready_q <= 1'b1;
            end else begin
                arready_q <= 1'b0;
            end
            if (rd_fire) begin
                rdata_q  <= regs_q[rd_idx];
                rvalid_q <= 1'b1;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = AXI_RESP_OKAY;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = AXI_RESP_OKAY;

    speaker_tone_gen u_tone (
        .clk        (clk),
        .srst       (srst),
        .enable_i   (regs_q[CTRL][CTRL_EN_BIT]),
        .period_i   (regs_q[PERIOD]),
        .note_len_i (regs_q[NOTE_LEN]),
        .speaker_o  (speaker_out),
        .busy_o     (tone_busy)
    );

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_sink;
    assign unused_sink = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], s00_axi_wstrb};

endmodule

// File: tb/tb_speaker_axi_slave.sv
// Directed testbench for speaker_axi_slave: register RW, write backpressure,
// byte strobes, same-cycle read/write ordering, tone timing and reset.
module tb_speaker_axi_slave;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        speaker_out;
    logic        tone_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    speaker_axi_slave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .speaker_out     (speaker_out),
        .tone_busy       (tone_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check_eq("wr_awready", {31'd0, awready}, 32'd1);
        check_eq("wr_wready", {31'd0, wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check_eq("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check_eq("wr_bresp", {30'd0, bresp}, 32'd0);
        $display("WR addr=0x%01h data=0x%08h strb=%04b", addr, data, strb);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check_eq("rd_arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check_eq("rd_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("rd_rresp", {30'd0, rresp}, 32'd0);
        data = rdata;
        $display("RD addr=0x%01h data=0x%08h", addr, data);
    endtask

    logic [31:0] rd;
    logic        spk_tr  [20];
    logic        busy_tr [20];

    initial begin
        int n;
        int rise;
        int fall;
        int ntog;
        int tog [8];
        logic [31:0] exp_strb;

        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_awready", {31'd0, awready}, 32'd0);
        check_eq("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_spk", {30'd0, speaker_out, tone_busy}, 32'd0);
        areset = 1'b0;

        // Register write/readback
        axi_write(4'h0, 32'd1, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h8, 32'd3, 4'hF);
        axi_write(4'hC, 32'd4, 4'hF);
        axi_read(4'h0, rd); check_eq("rb_reg0", rd, 32'd1);
        axi_read(4'h4, rd); check_eq("rb_reg1", rd, 32'd2);
        axi_read(4'h8, rd); check_eq("rb_reg2", rd, 32'd3);
        axi_read(4'hC, rd); check_eq("rb_reg3", rd, 32'd4);

        // Clear CTRL so the tone generator stays idle for now
        axi_write(4'h0, 32'd0, 4'hF);

        // Write response backpressure with a second write queued
        @(negedge clk);
        awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check_eq("bp_first_awready", {31'd0, awready}, 32'd1);
        @(negedge clk);
        wdata = 32'h7;
        check_eq("bp_bvalid_set", {31'd0, bvalid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
            check_eq("bp_awready_blocked", {31'd0, awready}, 32'd0);
        end
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        check_eq("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check_eq("bp_second_awready", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
        $display("WR addr=0xc data=0x00000099 then 0x00000007 under backpressure");
        axi_read(4'hC, rd); check_eq("bp_readback", rd, 32'h7);

        // Same-cycle write and read of SCRATCH: read sees the old value
        @(negedge clk);
        awaddr = 4'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'hC; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check_eq("rw_awready", {31'd0, awready}, 32'd1);
        check_eq("rw_arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("rw_bvalid", {31'd0, bvalid}, 32'd1);
        check_eq("rw_rvalid", {31'd0, rvalid}, 32'd1);
        check_eq("rw_old_data", rdata, 32'h7);
        $display("WR+RD addr=0xc wdata=0x00000055 rdata=0x%08h", rdata);
        axi_read(4'hC, rd); check_eq("rw_new_data", rd, 32'h55);

        // Byte strobes
        axi_write(4'hC, 32'h11223344, 4'hF);
        axi_write(4'hC, 32'hAABBCCDD, 4'b0010);
`ifdef SPEAKER_WSTRB_EN
        exp_strb = 32'h1122CC44;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        axi_read(4'hC, rd); check_eq("wstrb_readback", rd, exp_strb);

        // Tone: PERIOD=3, NOTE_LEN=4
        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h8, 32'd4, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            spk_tr[i]  = speaker_out;
            busy_tr[i] = tone_busy;
        end
        rise = -1; fall = -1; ntog = 0;
        for (int i = 0; i < 20; i++) begin
            if (rise < 0 && busy_tr[i]) rise = i;
            if (rise >= 0 && fall < 0 && !busy_tr[i]) fall = i;
            if (i > 0 && spk_tr[i] != spk_tr[i-1] && busy_tr[i] && ntog < 8) begin
                tog[ntog] = i;
                ntog++;
            end
        end
        check_eq("tone_start", rise, 32'd0);
        check_eq("tone_toggles", ntog, 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ntog) check_eq("tone_toggle_time", tog[k], 32'(3 * (k + 1)));
        end
        check_eq("tone_stop_time", fall, 32'd13);
        check_eq("tone_stop_spk", {31'd0, spk_tr[19]}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("tone_no_retrigger", {31'd0, tone_busy}, 32'd0);
        $display("TONE period=3 len=4 start=%0d toggles=%0d stop=%0d", rise, ntog, fall);

        // Re-trigger by clearing then setting enable, then stop by clearing it
        axi_write(4'h0, 32'd0, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        @(negedge clk);
        check_eq("retrig_busy", {31'd0, tone_busy}, 32'd1);
        axi_write(4'h0, 32'd0, 4'hF);
        @(negedge clk);
        check_eq("disable_stop", {30'd0, tone_busy, speaker_out}, 32'd0);

        // Endless tone, then reset with a write response pending
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h8, 32'd0, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        repeat (12) @(negedge clk);
        check_eq("endless_busy", {31'd0, tone_busy}, 32'd1);
        awaddr = 4'hC; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
        areset = 1'b1;
        @(negedge clk);
        check_eq("rst_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check_eq("rst_readies", {28'd0, awready, wready, arready, rvalid}, 32'd0);
        check_eq("rst_resp_data", rdata | {28'd0, bresp, rresp}, 32'd0);
        check_eq("rst_tone", {30'd0, tone_busy, speaker_out}, 32'd0);
        areset = 1'b0;
        bready = 1'b1;
        $display("RESET during pending write and endless tone");
        for (int r = 0; r < 4; r++) begin
            axi_read(4'(r * 4), rd);
            check_eq("rst_reg_zero", rd, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
